// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter unit.
//   SEL_W            width of the next-PC source select
//   SEL_SEQ..SEL_RET encodings of the next-PC source select (6 and 7 act as SEQ)
//   word_aligned()   true when an address has its two low bits clear
// ---------------------------------------------------------------------------
package pc_pkg;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_SEQ = 3'd0;
  localparam logic [SEL_W-1:0] SEL_BR  = 3'd1;
  localparam logic [SEL_W-1:0] SEL_J   = 3'd2;
  localparam logic [SEL_W-1:0] SEL_JR  = 3'd3;
  localparam logic [SEL_W-1:0] SEL_JAL = 3'd4;
  localparam logic [SEL_W-1:0] SEL_RET = 3'd5;

  function automatic logic word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras
// Return address stack kept as a circular buffer with a top pointer and an
// entry count. Pushing onto a full stack overwrites the oldest entry and sets
// the sticky overflow flag; popping an empty stack changes nothing.
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-low reset (empties the stack, clears ovf)
//   push   in   push din this cycle
//   pop    in   pop the top entry this cycle (never together with push)
//   din    in   WIDTH-bit value to push
//   top    out  WIDTH-bit value of the most recent entry
//   empty  out  stack holds no entries
//   full   out  stack holds RAS_DEPTH entries
//   ovf    out  sticky: a push overwrote the oldest entry
// ---------------------------------------------------------------------------
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [CNT_W-1:0] count;

  // With a power-of-two depth the pointer wraps naturally, so the slot after
  // the top of a full stack is exactly the oldest entry.
  assign next_ptr = top_ptr + PTR_W'(1);
  assign top      = mem[top_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      top_ptr <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else if (push) begin
      top_ptr <= next_ptr;
      if (full) begin
        ovf <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      top_ptr <= top_ptr - PTR_W'(1);
      count   <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[next_ptr] <= din;
    end
  end

endmodule

// File: rtl/pc_unit_param.sv
// ---------------------------------------------------------------------------
// pc_unit_param
// Parametrised program-counter unit. Holds the PC, selects the next PC from
// sequential / branch / jump / register-jump / JAL / return sources, keeps a
// return address stack, supports stalling and traps misaligned targets.
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-low reset (wins over en)
//   en          in   1 = advance, 0 = stall (state held, pulses drop)
//   sel         in   next-PC source (SEL_* in pc_pkg; 6,7 act as SEQ)
//   br_taken    in   branch condition, used only for SEL_BR
//   imm16       in   signed branch offset in words
//   tgt26       in   jump target field in words
//   reg_tgt     in   JR target and fallback target for RET on an empty stack
//   pc          out  current PC
//   pc_plus     out  pc + INC (combinational)
//   misaligned  out  pulse: the last update trapped to TRAP_VEC
//   ras_empty   out  return stack holds no entries
//   ras_full    out  return stack holds RAS_DEPTH entries
//   ras_ovf     out  sticky: a JAL push overwrote the oldest entry
//   ras_miss    out  pulse: RET issued while the return stack was empty
// ---------------------------------------------------------------------------
module pc_unit_param
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'('h80),
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic             br_taken,
  input  logic [15:0]      imm16,
  input  logic [25:0]      tgt26,
  input  logic [WIDTH-1:0] reg_tgt,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             misaligned,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_miss
);

  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] ras_top;
  logic             ret_miss;
  logic             trap;
  logic             ras_push;
  logic             ras_pop;

  assign pc_plus = pc + WIDTH'(INC);

  // Word offset sign-extended and scaled to bytes.
  assign br_off = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};

  // The jump keeps the region bits above bit 27 of the sequential PC; at the
  // minimum width there are none left to keep.
  generate
    if (WIDTH > 28) begin : g_jump_region
      assign jump_tgt = {pc_plus[WIDTH-1:28], tgt26, 2'b00};
    end else begin : g_jump_flat
      assign jump_tgt = {tgt26, 2'b00};
    end
  endgenerate

  // Next-PC candidate before the alignment check.
  always_comb begin
    cand     = pc_plus;
    ret_miss = 1'b0;
    case (sel)
      SEL_BR: begin
        if (br_taken) begin
          cand = pc_plus + br_off;
        end
      end
      SEL_J, SEL_JAL: cand = jump_tgt;
      SEL_JR:         cand = reg_tgt;
      SEL_RET: begin
        if (ras_empty) begin
          cand     = reg_tgt;
          ret_miss = 1'b1;
        end else begin
          cand = ras_top;
        end
      end
      default: cand = pc_plus;
    endcase
  end

  assign trap = !word_aligned(cand[1:0]);

  // A trapping cycle leaves the return stack untouched.
  assign ras_push = reset && en && (sel == SEL_JAL) && !trap;
  assign ras_pop  = reset && en && (sel == SEL_RET) && !trap && !ras_empty;

  // PC register and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_VEC;
      misaligned <= 1'b0;
      ras_miss   <= 1'b0;
    end else if (en) begin
      pc         <= trap ? TRAP_VEC : cand;
      misaligned <= trap;
      ras_miss   <= ret_miss;
    end else begin
      misaligned <= 1'b0;
      ras_miss   <= 1'b0;
    end
  end

  pc_ras #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk  (clk),
    .reset(reset),
    .push (ras_push),
    .pop  (ras_pop),
    .din  (pc_plus),
    .top  (ras_top),
    .empty(ras_empty),
    .full (ras_full),
    .ovf  (ras_ovf)
  );

endmodule

// File: tb/tb_pc_unit_param.sv
// ---------------------------------------------------------------------------
// tb_pc_unit_param
// Directed vector table for the documented scenarios followed by random
// traffic compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_pc_unit_param;
  import pc_pkg::*;

  localparam int WIDTH     = 32;
  localparam int RAS_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [2:0]        sel;
  logic              br_taken;
  logic [15:0]       imm16;
  logic [25:0]       tgt26;
  logic [WIDTH-1:0]  reg_tgt;
  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  pc_plus;
  logic              misaligned;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_ovf;
  logic              ras_miss;

  int vectors_applied = 0;
  int miscompares     = 0;

  typedef struct {
    logic        r;
    logic        e;
    logic [2:0]  s;
    logic        bt;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] rt;
    logic [31:0] exp_pc;
    logic        exp_mis;
    logic        exp_miss;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: the stack is a queue, newest entry at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf;
  logic        m_mis;
  logic        m_miss;

  pc_unit_param #(
    .WIDTH    (WIDTH),
    .RESET_VEC(32'h0),
    .TRAP_VEC (32'h80),
    .INC      (4),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sel       (sel),
    .br_taken  (br_taken),
    .imm16     (imm16),
    .tgt26     (tgt26),
    .reg_tgt   (reg_tgt),
    .pc        (pc),
    .pc_plus   (pc_plus),
    .misaligned(misaligned),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_miss  (ras_miss)
  );

  always #5 clk = ~clk;

  task automatic add_vec(input logic r, input logic e, input logic [2:0] s,
                         input logic bt, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic [31:0] rt,
                         input logic [31:0] exp_pc, input logic exp_mis,
                         input logic exp_miss, input logic exp_empty,
                         input logic exp_full, input logic exp_ovf);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.bt = bt; v.imm = imm; v.tgt = tgt; v.rt = rt;
    v.exp_pc = exp_pc; v.exp_mis = exp_mis; v.exp_miss = exp_miss;
    v.exp_empty = exp_empty; v.exp_full = exp_full; v.exp_ovf = exp_ovf;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge, well clear of the active edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] s,
                               input logic bt, input logic [15:0] imm,
                               input logic [25:0] tgt, input logic [31:0] rt);
    @(negedge clk);
    reset    = r;
    en       = e;
    sel      = s;
    br_taken = bt;
    imm16    = imm;
    tgt26    = tgt;
    reg_tgt  = rt;
  endtask

  // Outputs are sampled 1 time unit after the rising edge that consumed the inputs.
  task automatic checkOutput(input string name, input logic [31:0] exp_pc,
                             input logic exp_mis, input logic exp_miss,
                             input logic exp_empty, input logic exp_full,
                             input logic exp_ovf);
    logic [31:0] exp_plus;
    exp_plus = exp_pc + 32'd4;
    @(posedge clk);
    #1;
    vectors_applied++;
    if (pc !== exp_pc || pc_plus !== exp_plus || misaligned !== exp_mis ||
        ras_miss !== exp_miss || ras_empty !== exp_empty ||
        ras_full !== exp_full || ras_ovf !== exp_ovf) begin
      miscompares++;
      $display("[TB] FAIL %s: got pc=%h pc_plus=%h mis=%b miss=%b empty=%b full=%b ovf=%b, expected pc=%h pc_plus=%h mis=%b miss=%b empty=%b full=%b ovf=%b",
               name, pc, pc_plus, misaligned, ras_miss, ras_empty, ras_full, ras_ovf,
               exp_pc, exp_plus, exp_mis, exp_miss, exp_empty, exp_full, exp_ovf);
    end
  endtask

  // Architectural next-state rules written directly as arithmetic on the PC
  // and operations on a bounded LIFO of return addresses.
  task automatic model_step(input logic r, input logic e, input logic [2:0] s,
                            input logic bt, input logic [15:0] imm,
                            input logic [25:0] tgt, input logic [31:0] rt);
    logic [31:0] seq_pc;
    logic [31:0] target;
    logic        missed;
    logic        trapped;
    seq_pc = m_pc + 32'd4;
    missed = 1'b0;
    if (!r) begin
      m_pc   = 32'h0;
      m_ras.delete();
      m_ovf  = 1'b0;
      m_mis  = 1'b0;
      m_miss = 1'b0;
    end else if (!e) begin
      m_mis  = 1'b0;
      m_miss = 1'b0;
    end else begin
      case (s)
        3'd1:       target = bt ? seq_pc + 32'(4 * int'($signed(imm))) : seq_pc;
        3'd2, 3'd4: target = (seq_pc & 32'hF000_0000) | (32'(tgt) * 32'd4);
        3'd3:       target = rt;
        3'd5: begin
          if (m_ras.size() > 0) begin
            target = m_ras[m_ras.size()-1];
          end else begin
            target = rt;
            missed = 1'b1;
          end
        end
        default:    target = seq_pc;
      endcase
      trapped = (target % 32'd4) != 32'd0;
      m_pc    = trapped ? 32'h80 : target;
      m_mis   = trapped;
      m_miss  = missed;
      if (!trapped && s == 3'd4) begin
        m_ras.push_back(seq_pc);
        if (m_ras.size() > RAS_DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
      if (!trapped && s == 3'd5 && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  initial begin
    logic        r, e, bt;
    logic [2:0]  s;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] rt;
    int          pick;

    reset    = 1'b0;
    en       = 1'b0;
    sel      = 3'd0;
    br_taken = 1'b0;
    imm16    = '0;
    tgt26    = '0;
    reg_tgt  = '0;
    m_pc     = 32'h0;
    m_ovf    = 1'b0;
    m_mis    = 1'b0;
    m_miss   = 1'b0;

    //       r  e  sel  bt imm       tgt     reg_tgt        exp_pc        mis miss emp full ovf
    // Reset wins over a pending JAL, then sequential stepping.
    add_vec(0, 1, 3'd4, 0, 16'h0000, 26'h40, 32'h0,         32'h0,         0, 0, 1, 0, 0);
    add_vec(1, 1, 3'd0, 0, 16'h0000, 26'h0,  32'h0,         32'h4,         0, 0, 1, 0, 0);
    add_vec(1, 1, 3'd0, 0, 16'h0000, 26'h0,  32'h0,         32'h8,         0, 0, 1, 0, 0);
    add_vec(1, 1, 3'd0, 0, 16'h0000, 26'h0,  32'h0,         32'hC,         0, 0, 1, 0, 0);
    // Branch taken backwards and not taken, both from 0x10.
    add_vec(1, 1, 3'd3, 0, 16'h0000, 26'h0,  32'h10,        32'h10,        0, 0, 1, 0, 0);
    add_vec(1, 1, 3'd1, 1, 16'hFFFE, 26'h0,  32'h0,         32'hC,         0, 0, 1, 0, 0);
    add_vec(1, 1, 3'd3, 0, 16'h0000, 26'h0,  32'h10,        32'h10,        0, 0, 1, 0, 0);
    add_vec(1, 1, 3'd1, 0, 16'hFFFE, 26'h0,  32'h0,         32'h14,        0, 0, 1, 0, 0);
    // Region-preserving jump, then a misaligned JR that traps.
    add_vec(1, 1, 3'd3, 0, 16'h0000, 26'h0,  32'h1000_0000, 32'h1000_0000, 0, 0, 1, 0, 0);
    add_vec(1, 1, 3'd2, 0, 16'h0000, 26'h40, 32'h0,         32'h1000_0100, 0, 0, 1, 0, 0);
    add_vec(1, 1, 3'd3, 0, 16'h0000, 26'h0,  32'h3,         32'h80,        1, 0, 1, 0, 0);
    add_vec(1, 1, 3'd7, 0, 16'h0000, 26'h0,  32'h0,         32'h84,        0, 0, 1, 0, 0);
    // Five JALs overflow a depth-4 stack, four RETs unwind it, a fifth misses.
    add_vec(0, 1, 3'd0, 0, 16'h0000, 26'h0,  32'h0,         32'h0,         0, 0, 1, 0, 0);
    add_vec(1, 1, 3'd4, 0, 16'h0000, 26'h40, 32'h0,         32'h100,       0, 0, 0, 0, 0);
    add_vec(1, 1, 3'd4, 0, 16'h0000, 26'h80, 32'h0,         32'h200,       0, 0, 0, 0, 0);
    add_vec(1, 1, 3'd4, 0, 16'h0000, 26'hC0, 32'h0,         32'h300,       0, 0, 0, 0, 0);
    add_vec(1, 1, 3'd4, 0, 16'h0000, 26'h100,32'h0,         32'h400,       0, 0, 0, 1, 0);
    add_vec(1, 1, 3'd4, 0, 16'h0000, 26'h140,32'h0,         32'h500,       0, 0, 0, 1, 1);
    add_vec(1, 1, 3'd5, 0, 16'h0000, 26'h0,  32'h0,         32'h404,       0, 0, 0, 0, 1);
    add_vec(1, 1, 3'd5, 0, 16'h0000, 26'h0,  32'h0,         32'h304,       0, 0, 0, 0, 1);
    add_vec(1, 1, 3'd5, 0, 16'h0000, 26'h0,  32'h0,         32'h204,       0, 0, 0, 0, 1);
    add_vec(1, 1, 3'd5, 0, 16'h0000, 26'h0,  32'h0,         32'h104,       0, 0, 1, 0, 1);
    add_vec(1, 1, 3'd5, 0, 16'h0000, 26'h0,  32'h20,        32'h20,        0, 1, 1, 0, 1);
    add_vec(1, 1, 3'd0, 0, 16'h0000, 26'h0,  32'h0,         32'h24,        0, 0, 1, 0, 1);
    // Stall with a jump pending, then reset during the stall.
    add_vec(1, 0, 3'd2, 0, 16'h0000, 26'h40, 32'h0,         32'h24,        0, 0, 1, 0, 1);
    add_vec(1, 0, 3'd2, 0, 16'h0000, 26'h40, 32'h0,         32'h24,        0, 0, 1, 0, 1);
    add_vec(1, 0, 3'd2, 0, 16'h0000, 26'h40, 32'h0,         32'h24,        0, 0, 1, 0, 1);
    add_vec(0, 0, 3'd2, 0, 16'h0000, 26'h40, 32'h0,         32'h0,         0, 0, 1, 0, 0);
    // Wrap at the top of the address space.
    add_vec(1, 1, 3'd3, 0, 16'h0000, 26'h0,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 1, 0, 0);
    add_vec(1, 1, 3'd0, 0, 16'h0000, 26'h0,  32'h0,         32'h0,         0, 0, 1, 0, 0);
    // RET on an empty stack with a misaligned fallback: miss and trap together.
    add_vec(1, 1, 3'd5, 0, 16'h0000, 26'h0,  32'h22,        32'h80,        1, 1, 1, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].e, vecs[i].s, vecs[i].bt,
                    vecs[i].imm, vecs[i].tgt, vecs[i].rt);
      checkOutput($sformatf("dir%0d", i), vecs[i].exp_pc, vecs[i].exp_mis,
                  vecs[i].exp_miss, vecs[i].exp_empty, vecs[i].exp_full,
                  vecs[i].exp_ovf);
    end

    // Held reset with a JAL pending: the stack must stay empty throughout.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 3'd4, 1'b0, 16'h0, 26'h40, 32'h0);
      checkOutput($sformatf("hold_reset%0d", k), 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Random traffic; the first cycle is a reset so the model starts in step.
    for (int i = 0; i < 600; i++) begin
      r    = (i == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      e    = ($urandom_range(0, 4) != 0);
      pick = $urandom_range(0, 9);
      if (pick < 3)      s = 3'd4;
      else if (pick < 6) s = 3'd5;
      else               s = 3'($urandom_range(0, 7));
      bt   = 1'($urandom_range(0, 1));
      imm  = 16'($urandom);
      tgt  = 26'($urandom);
      rt   = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      applyStimulus(r, e, s, bt, imm, tgt, rt);
      model_step(r, e, s, bt, imm, tgt, rt);
      checkOutput($sformatf("rand%0d", i), m_pc, m_mis, m_miss,
                  (m_ras.size() == 0), (m_ras.size() == RAS_DEPTH), m_ovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
